sindrome_to_7seg: RTL and testbench

SINDROME_TO_7SEG -- requirements
Module: sindrome_to_7seg

---
 rtl/sindrome_to_7seg.sv | 51 +++++
 tb/tb_sindrome_to_7seg.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sindrome_to_7seg.sv
// Decodes a 3-bit Hamming syndrome to a registered 7-segment hex glyph and a nonzero-syndrome flag.
// Latency: 1 core clock from sin/blank to seg/err. Reset forces the display blank.
// Backpressure: none; a new input is accepted every cycle.
module sindrome_to_7seg #(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sin,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       err
);

    // Segment polarity mask; reset and blank are "all off" in the logical domain too.
    localparam logic [6:0] POL_MASK = {7{SEG_ACTIVE_LOW}};
    localparam logic [6:0] SEG_OFF  = 7'h00 ^ POL_MASK;

    logic [6:0] glyph;
    logic [6:0] seg_nxt;

    always_comb begin
        glyph = 7'h00;
        case (sin)
            3'd0: glyph = 7'h3F;
            3'd1: glyph = 7'h06;
            3'd2: glyph = 7'h5B;
            3'd3: glyph = 7'h4F;
            3'd4: glyph = 7'h66;
            3'd5: glyph = 7'h6D;
            3'd6: glyph = 7'h7D;
            3'd7: glyph = 7'h07;
        endcase
    end

    always_comb begin
        seg_nxt = blank ? 7'h00 : glyph;
        seg_nxt = seg_nxt ^ POL_MASK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_OFF;
            err <= 1'b0;
        end else begin
            seg <= seg_nxt;
            err <= (sin != 3'd0);
        end
    end

endmodule

// File: tb/tb_sindrome_to_7seg.sv
// Self-checking bench for sindrome_to_7seg: both display polarities driven in parallel from
// one stimulus stream, checked against spec vectors, corner sequences and a random reference model.
module tb_sindrome_to_7seg;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sin;
    logic       blank;
    logic [6:0] seg_hi;
    logic [6:0] seg_lo;
    logic       err_hi;
    logic       err_lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sindrome_to_7seg #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
        .clk   (clk),
        .rst   (rst),
        .sin   (sin),
        .blank (blank),
        .seg   (seg_hi),
        .err   (err_hi)
    );

    sindrome_to_7seg #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
        .clk   (clk),
        .rst   (rst),
        .sin   (sin),
        .blank (blank),
        .seg   (seg_lo),
        .err   (err_lo)
    );

    typedef struct {
        logic [2:0] sin;
        logic       blank;
        logic [6:0] seg;
        logic [6:0] seg_al;
        logic       err;
    } vec_t;

    vec_t vecs [12];

    // Hex digit glyphs (g..a), indexed by digit value.
    logic [6:0] glyph [0:7] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

    typedef struct {
        logic [2:0] sin;
        logic       blank;
    } in_t;

    in_t pending [$];

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [6:0] e_seg,
                             input logic [6:0] e_seg_al, input logic e_err);
        chk({name, ".seg"},    seg_hi,         e_seg);
        chk({name, ".seg_al"}, seg_lo,         e_seg_al);
        chk({name, ".err"},    {6'b0, err_hi}, {6'b0, e_err});
        chk({name, ".err_al"}, {6'b0, err_lo}, {6'b0, e_err});
    endtask

    task automatic apply_and_clock(input logic [2:0] s, input logic b);
        sin   = s;
        blank = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] m_seg;
        logic       m_err;
        in_t        cur;
        in_t        old;

        vecs[0]  = '{3'd0, 1'b0, 7'h3F, 7'h40, 1'b0};
        vecs[1]  = '{3'd1, 1'b0, 7'h06, 7'h79, 1'b1};
        vecs[2]  = '{3'd2, 1'b0, 7'h5B, 7'h24, 1'b1};
        vecs[3]  = '{3'd3, 1'b0, 7'h4F, 7'h30, 1'b1};
        vecs[4]  = '{3'd4, 1'b0, 7'h66, 7'h19, 1'b1};
        vecs[5]  = '{3'd5, 1'b0, 7'h6D, 7'h12, 1'b1};
        vecs[6]  = '{3'd6, 1'b0, 7'h7D, 7'h02, 1'b1};
        vecs[7]  = '{3'd7, 1'b0, 7'h07, 7'h78, 1'b1};
        vecs[8]  = '{3'd5, 1'b1, 7'h00, 7'h7F, 1'b1};
        vecs[9]  = '{3'd5, 1'b0, 7'h6D, 7'h12, 1'b1};
        vecs[10] = '{3'd0, 1'b1, 7'h00, 7'h7F, 1'b0};
        vecs[11] = '{3'd7, 1'b1, 7'h00, 7'h7F, 1'b1};

        rst   = 1'b1;
        sin   = 3'd6;
        blank = 1'b0;
        #3;
        check_all("reset", 7'h00, 7'h7F, 1'b0);

        // Release between edges; the first edge must load the current inputs.
        #9;
        rst = 1'b0;
        foreach (vecs[i]) begin
            apply_and_clock(vecs[i].sin, vecs[i].blank);
            check_all($sformatf("vec%0d", i), vecs[i].seg, vecs[i].seg_al, vecs[i].err);
        end

        // Back-to-back changes 1,2,3 with one cycle of lag.
        apply_and_clock(3'd1, 1'b0);
        check_all("seq1", 7'h06, 7'h79, 1'b1);
        apply_and_clock(3'd2, 1'b0);
        check_all("seq2", 7'h5B, 7'h24, 1'b1);
        apply_and_clock(3'd3, 1'b0);
        check_all("seq3", 7'h4F, 7'h30, 1'b1);

        // Mid-cycle asynchronous reset while showing 6.
        apply_and_clock(3'd6, 1'b0);
        check_all("pre_rst", 7'h7D, 7'h02, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 7'h00, 7'h7F, 1'b0);
        sin = 3'd3;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst", 7'h4F, 7'h30, 1'b1);

        // Random stream against the reference model.
        for (int n = 0; n < 300; n++) begin
            cur.sin   = 3'($urandom_range(0, 7));
            cur.blank = ($urandom_range(0, 3) == 0);
            pending.push_back(cur);
            apply_and_clock(cur.sin, cur.blank);
            old   = pending.pop_front();
            m_seg = old.blank ? 7'h00 : glyph[old.sin];
            m_err = (old.sin != 3'd0);
            check_all($sformatf("rand%0d", n), m_seg, ~m_seg, m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
